// File: rtl/aes_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : aes_output_buffer
// Description : Captures a 128-bit AES result and serializes it as four
//               32-bit words, least-significant word first, under valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_output_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic         done_i,
  input  logic [127:0] text_i,
  input  logic         ready_i,
  output logic [31:0]  text_o,
  output logic         valid_o,
  output logic         last_o,
  output logic         busy_o,
  output logic         ovf_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
  localparam logic [1:0] IDX_LAST = 2'd3;

  logic [0:0]   state;
  logic [1:0]   idx;
  logic [127:0] hold;
  logic         ovf;

  logic         sending;
  logic         xfer;
  logic         last_xfer;
  logic         accept;

  assign sending   = (state == ST_SEND);
  assign xfer      = sending && ready_i;
  assign last_xfer = xfer && (idx == IDX_LAST);
  // A new block can only land when the buffer is empty or draining its last word.
  assign accept    = done_i && (!sending || last_xfer);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
      hold  <= 128'd0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        hold  <= text_i;
        idx   <= 2'd0;
        state <= ST_SEND;
      end else if (xfer) begin
        if (idx == IDX_LAST) begin
          state <= ST_IDLE;
          idx   <= 2'd0;
        end else begin
          idx <= idx + 2'd1;
        end
      end

      if (done_i && !accept) begin
        ovf <= 1'b1;
      end
    end
  end

  // Outputs depend only on registered state; IDLE forces the word to zero.
  assign text_o  = sending ? hold[32*idx +: 32] : 32'd0;
  assign valid_o = sending;
  assign last_o  = sending && (idx == IDX_LAST);
  assign busy_o  = sending;
  assign ovf_o   = ovf;

endmodule
`default_nettype wire

// File: tb/tb_aes_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_output_buffer
// Description : Directed self-checking bench for aes_output_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_output_buffer;

  logic         clk;
  logic         rst;
  logic         done_i;
  logic [127:0] text_i;
  logic         ready_i;
  logic [31:0]  text_o;
  logic         valid_o;
  logic         last_o;
  logic         busy_o;
  logic         ovf_o;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK_A = 128'h33333333_22222222_11111111_00000000;
  localparam logic [127:0] BLK_B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  aes_output_buffer dut (
    .clk     (clk),
    .rst     (rst),
    .done_i  (done_i),
    .text_i  (text_i),
    .ready_i (ready_i),
    .text_o  (text_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected word/valid/last/busy/ovf.
  task automatic expect_out(input string tag, input logic [31:0] w, input logic v,
                            input logic l, input logic b, input logic o);
    check({tag, ".text"},  text_o,  w);
    check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
    check({tag, ".last"},  {31'd0, last_o},  {31'd0, l});
    check({tag, ".busy"},  {31'd0, busy_o},  {31'd0, b});
    check({tag, ".ovf"},   {31'd0, ovf_o},   {31'd0, o});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b0;
    done_i  = 1'b0;
    text_i  = 128'd0;
    ready_i = 1'b0;

    // Reset held with random activity on every input
    for (int i = 0; i < 4; i++) begin
      done_i  = 1'b1;
      text_i  = {$urandom, $urandom, $urandom, $urandom};
      ready_i = 1'($urandom);
      step();
      expect_out("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    done_i = 1'b0;
    rst    = 1'b1;
    step();
    step();
    expect_out("reset_release", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic serialization
    done_i = 1'b1; text_i = BLK_A; ready_i = 1'b1;
    step();
    done_i = 1'b0; text_i = 128'd0;
    expect_out("basic_w0", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("basic_w1", 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("basic_w2", 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("basic_w3", 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("basic_idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure before word 2
    done_i = 1'b1; text_i = BLK_A; ready_i = 1'b1;
    step();
    done_i = 1'b0;
    expect_out("bp_w0", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("bp_w1", 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("bp_stall", 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    expect_out("bp_stall_end", 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0);
    ready_i = 1'b1;
    step();
    expect_out("bp_w3", 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("bp_idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: second done coincides with transfer of the last word
    done_i = 1'b1; text_i = BLK_A; ready_i = 1'b1;
    step();
    done_i = 1'b0;
    expect_out("b2b_a0", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("b2b_a1", 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("b2b_a2", 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("b2b_a3", 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b0);
    done_i = 1'b1; text_i = BLK_B;
    step();
    done_i = 1'b0; text_i = 128'd0;
    expect_out("b2b_b0", 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("b2b_b1", 32'hBBBBBBBB, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("b2b_b2", 32'hCCCCCCCC, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("b2b_b3", 32'hDDDDDDDD, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    expect_out("b2b_idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Overflow: done while word 1 of block A is stalled
    done_i = 1'b1; text_i = BLK_A; ready_i = 1'b1;
    step();
    done_i = 1'b0;
    expect_out("ovf_a0", 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("ovf_a1", 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0);
    ready_i = 1'b0; done_i = 1'b1; text_i = BLK_B;
    step();
    done_i = 1'b0; text_i = 128'd0;
    expect_out("ovf_set", 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b1);
    ready_i = 1'b1;
    step();
    expect_out("ovf_a2", 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    expect_out("ovf_a3", 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    expect_out("ovf_idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    done_i = 1'b1; text_i = BLK_B;
    step();
    done_i = 1'b0;
    expect_out("ovf_next_b0", 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    expect_out("ovf_next_b1", 32'hBBBBBBBB, 1'b1, 1'b0, 1'b1, 1'b1);
    step(); step(); step();
    expect_out("ovf_next_idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while word 2 is presented
    done_i = 1'b1; text_i = BLK_A; ready_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
    step();
    expect_out("mid_w2", 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    expect_out("mid_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    done_i = 1'b1; text_i = BLK_B;
    step();
    done_i = 1'b0;
    expect_out("mid_restart_w0", 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("mid_restart_w1", 32'hBBBBBBBB, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
